instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
- IF stage of the 5-stage MIPS pipeline.
- Owns the PC and fetches from instruction memory over a req/ready + rvalid handshake.
- Loads the IF/ID register that feeds instruction decode.
- Consumes decode's resolved redirect (branch_taken/branch_address, jump/jump_address) and stall (Data_Hazard); produces Control_Hazard so decode squashes the wrong-path instruction.

Parameters:
- PC_WIDTH, 10, PC/address width in bytes; matches pc_plus4 width.
- RESET_PC, 10'd0, PC value after reset.
- NOP_INSTR, 32'h0000_0000, instruction placed in IF/ID when flushed or empty.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- branch_taken  in  1  ID: conditional branch taken.
- branch_address  in  PC_WIDTH  ID: branch target.
- jump  in  1  ID: unconditional jump.
- jump_address  in  PC_WIDTH  ID: jump target.
- Data_Hazard  in  1  ID stall; hold IF/ID and PC.
- imem_req  out  1  fetch request valid.
- imem_addr  out  PC_WIDTH  fetch byte address (word aligned).
- imem_ready  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid, in order, one per accepted request.
- imem_rdata  in  32  instruction word.
- if_id_instr  out  32  IF/ID instruction.
- if_id_pc_plus4  out  PC_WIDTH  IF/ID PC+4 of that instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
- Control_Hazard  out  1  redirect accepted this cycle (combinational).

Behaviour:
- Reset (reset=0, async):
  - pc=RESET_PC; state=S_REQ; kill=0.
  - if_id_instr=NOP_INSTR; if_id_pc_plus4=0; if_id_valid=0.
  - imem_req=0 while in reset; asserts the first cycle after release.
- redirect = (jump | branch_taken) & ~Data_Hazard.
  - target = jump ? jump_address : branch_address (jump wins).
  - Control_Hazard = redirect.
- States:
  - S_REQ:
    - imem_req=1, imem_addr=pc.
    - On imem_ready: in_pc<=pc, go S_WAIT.
  - S_WAIT:
    - imem_req=0.
    - On imem_rvalid with kill=1: drop data, kill<=0, go S_REQ.
    - On imem_rvalid with kill=0 and ~Data_Hazard: IF/ID<= {imem_rdata, in_pc+4, valid=1}; pc<=in_pc+4; go S_REQ.
    - On imem_rvalid with kill=0 and Data_Hazard: capture into skid {instr, pc+4}; go S_HOLD.
  - S_HOLD:
    - imem_req=0.
    - When ~Data_Hazard: IF/ID<=skid; pc<=skid pc+4; go S_REQ.
- IF/ID when not loaded:
  - If Data_Hazard=1: hold all IF/ID fields.
  - Else: if_id_valid<=0, if_id_instr<=NOP_INSTR.
- Redirect (highest priority, overrides all above in the same cycle):
  - pc<=target; IF/ID<= {NOP_INSTR, 0, valid=0}.
  - S_REQ with imem_ready same cycle: go S_WAIT, kill<=1.
  - S_REQ without imem_ready: stay, next request uses target.
  - S_WAIT, rvalid not yet seen: kill<=1.
  - S_WAIT, rvalid same cycle: data dropped, go S_REQ.
  - S_HOLD: skid dropped, go S_REQ.
- Redirect with Data_Hazard=1 is ignored; decode re-presents it after the stall.
- Arithmetic:
  - PC+4 is modulo 2^PC_WIDTH; wrap 10'h3FC -> 10'h000 is required.
  - Targets are used as given; bits [1:0] forced to 0 on imem_addr.
- Latency: with rvalid one cycle after ready and no stall, the instruction is visible in IF/ID 2 cycles after imem_req; steady throughput is 1 instruction per 2 cycles.
- Exactly one outstanding request; imem_req is never asserted in S_WAIT or S_HOLD.

Optional Feature:
- Macro IF_PERF_COUNTERS_EN.
- Defined: adds outputs perf_fetched[31:0], perf_killed[15:0], perf_stall[31:0], all reset to 0 and saturating.
  - perf_fetched: +1 per IF/ID load with valid=1.
  - perf_killed: +1 per dropped response or dropped skid entry.
  - perf_stall: +1 per cycle with Data_Hazard=1.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package mips_pkg:
  - PC_WIDTH, INSTR_WIDTH=32, NOP_INSTR.
  - Fetch state enum {S_REQ, S_WAIT, S_HOLD}, 2-bit encoding.
- One sub-module if_id_reg: IF/ID register with load, hold (stall) and flush inputs; flush has priority over hold.

Test Plan:
- Reset release, memory returns 32'h2008_0005 at 0x000 (ready=1, rvalid next cycle) -> imem_addr=0x000; IF/ID = {32'h2008_0005, 0x004, 1} two cycles after reset deassert; next imem_addr=0x004.
- Data_Hazard=1 for 3 cycles while rvalid returns 0x008 data -> IF/ID holds the prior instruction; skid captures; after release IF/ID={data@0x008, 0x00C}, next imem_addr=0x00C.
- branch_taken=1, branch_address=0x040 while in S_WAIT for 0x010 -> Control_Hazard=1 that cycle; 0x010 response dropped; next imem_addr=0x040; if_id_valid=0 in between.
- jump=1 (0x100) and branch_taken=1 (0x040) same cycle -> next fetch address 0x100.
- branch_taken=1 with Data_Hazard=1 -> no redirect, Control_Hazard=0, PC unchanged.
- PC=0x3FC fetched, no redirect -> if_id_pc_plus4=0x000, next imem_addr=0x000; reset asserted mid-S_WAIT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared widths, constants and fetch FSM encoding for the MIPS pipeline.
package mips_pkg;

    localparam int unsigned PC_WIDTH    = 10;
    localparam int unsigned INSTR_WIDTH = 32;

    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_if_id_reg.sv
// IF/ID pipeline register: flush beats load, load beats hold, otherwise a bubble.
module if_id_reg
    import mips_pkg::*;
#(
    parameter int unsigned            PC_WIDTH  = mips_pkg::PC_WIDTH,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic                   hold,
    input  logic                   flush,
    input  logic [INSTR_WIDTH-1:0] instr_in,
    input  logic [PC_WIDTH-1:0]    pc_plus4_in,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]    pc_plus4,
    output logic                   valid
);

    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [PC_WIDTH-1:0]    pc_plus4_q, pc_plus4_d;
    logic                   valid_q, valid_d;

    always_comb begin
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (flush) begin
            instr_d    = NOP_INSTR;
            pc_plus4_d = '0;
            valid_d    = 1'b0;
        end else if (load) begin
            instr_d    = instr_in;
            pc_plus4_d = pc_plus4_in;
            valid_d    = 1'b1;
        end else if (!hold) begin
            // Nothing arrived and decode is not stalled: present a bubble.
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr    = instr_q;
    assign pc_plus4 = pc_plus4_q;
    assign valid    = valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// MIPS IF stage: PC, single-outstanding imem fetch, skid on stall, redirect/kill.
// Optional performance counters are enabled with `define IF_PERF_COUNTERS_EN.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter int unsigned            PC_WIDTH  = mips_pkg::PC_WIDTH,
    parameter logic [PC_WIDTH-1:0]    RESET_PC  = '0,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_address,
    input  logic                   jump,
    input  logic [PC_WIDTH-1:0]    jump_address,
    input  logic                   Data_Hazard,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ready,
    input  logic                   imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] if_id_instr,
    output logic [PC_WIDTH-1:0]    if_id_pc_plus4,
    output logic                   if_id_valid,
    output logic                   Control_Hazard
`ifdef IF_PERF_COUNTERS_EN
    ,
    output logic [31:0]            perf_fetched,
    output logic [15:0]            perf_killed,
    output logic [31:0]            perf_stall
`endif
);

    fetch_state_e           state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [PC_WIDTH-1:0]    in_pc_q, in_pc_d;
    logic [PC_WIDTH-1:0]    skid_pc4_q, skid_pc4_d;
    logic [INSTR_WIDTH-1:0] skid_instr_q, skid_instr_d;
    logic                   kill_q, kill_d;
    logic                   req_q, req_d;

    logic                   redirect_c;
    logic                   fire_c;
    logic                   load_c;
    logic [PC_WIDTH-1:0]    target_c;
    logic [PC_WIDTH-1:0]    in_pc_plus4_c;
    logic [INSTR_WIDTH-1:0] load_instr_c;
    logic [PC_WIDTH-1:0]    load_pc4_c;

    assign redirect_c    = (jump | branch_taken) & ~Data_Hazard;
    assign target_c      = jump ? jump_address : branch_address;
    assign fire_c        = req_q & imem_ready;
    assign in_pc_plus4_c = in_pc_q + PC_WIDTH'(4);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        in_pc_d      = in_pc_q;
        kill_d       = kill_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        load_c       = 1'b0;
        load_instr_c = imem_rdata;
        load_pc4_c   = in_pc_plus4_c;

        case (state_q)
            S_REQ: begin
                if (fire_c) begin
                    in_pc_d = pc_q;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_REQ;
                    end else if (!Data_Hazard) begin
                        load_c  = 1'b1;
                        pc_d    = in_pc_plus4_c;
                        state_d = S_REQ;
                    end else begin
                        skid_instr_d = imem_rdata;
                        skid_pc4_d   = in_pc_plus4_c;
                        state_d      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!Data_Hazard) begin
                    load_c       = 1'b1;
                    load_instr_c = skid_instr_q;
                    load_pc4_c   = skid_pc4_q;
                    pc_d         = skid_pc4_q;
                    state_d      = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        // Redirect wins over everything; an in-flight response becomes wrong-path.
        if (redirect_c) begin
            pc_d   = target_c;
            load_c = 1'b0;
            case (state_q)
                S_REQ:   kill_d = fire_c;
                S_WAIT: begin
                    kill_d  = ~imem_rvalid;
                    state_d = imem_rvalid ? S_REQ : S_WAIT;
                end
                default: state_d = S_REQ;
            endcase
        end

        req_d = (state_d == S_REQ);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            in_pc_q      <= RESET_PC;
            kill_q       <= 1'b0;
            req_q        <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pc4_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            in_pc_q      <= in_pc_d;
            kill_q       <= kill_d;
            req_q        <= req_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
        end
    end

    assign imem_req       = req_q;
    assign imem_addr      = {pc_q[PC_WIDTH-1:2], 2'b00};
    assign Control_Hazard = redirect_c;

    if_id_reg #(
        .PC_WIDTH  (PC_WIDTH),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk         (clk),
        .rst_n       (reset),
        .load        (load_c),
        .hold        (Data_Hazard),
        .flush       (redirect_c),
        .instr_in    (load_instr_c),
        .pc_plus4_in (load_pc4_c),
        .instr       (if_id_instr),
        .pc_plus4    (if_id_pc_plus4),
        .valid       (if_id_valid)
    );

`ifdef IF_PERF_COUNTERS_EN
    logic [31:0] fetched_q, fetched_d;
    logic [15:0] killed_q, killed_d;
    logic [31:0] stall_q, stall_d;
    logic        drop_c;

    // Saturating event counters.
    always_comb begin
        drop_c    = ((state_q == S_WAIT) && imem_rvalid && (kill_q || redirect_c))
                 || ((state_q == S_HOLD) && redirect_c);
        fetched_d = fetched_q;
        killed_d  = killed_q;
        stall_d   = stall_q;
        if (load_c && (fetched_q != '1)) fetched_d = fetched_q + 32'd1;
        if (drop_c && (killed_q != '1))  killed_d  = killed_q + 16'd1;
        if (Data_Hazard && (stall_q != '1)) stall_d = stall_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetched_q <= '0;
            killed_q  <= '0;
            stall_q   <= '0;
        end else begin
            fetched_q <= fetched_d;
            killed_q  <= killed_d;
            stall_q   <= stall_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_killed  = killed_q;
    assign perf_stall   = stall_q;
`endif

endmodule
